// File: rtl/canny_pkg.sv
// Shared constants and types for the frame-buffer SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package canny_pkg;

    localparam int ADDR_W     = 18;   // 512x512 pixel address
    localparam int DATA_W     = 8;    // one pixel
    localparam int IMG_W      = 512;
    localparam int IMG_H      = 512;
    localparam int WBUF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DUMP   = 2'd2
    } arb_state_t;

    // Which side received the most recent SRAM slot.
    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Write buffer: circular FIFO of {addr,data} entries with per-entry address compare.
// Latency: push visible at the head the cycle after; pop takes effect at the next edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk/rst; push_i + push_addr_i/push_data_i; pop_i; head_addr_o/head_data_o;
//        cmp_addr_i -> match_o[i] (entry i valid and holds cmp_addr_i); full_o/empty_o/count_o.
module wbuf_fifo #(
    parameter int ADDR_W = canny_pkg::ADDR_W,
    parameter int DATA_W = canny_pkg::DATA_W,
    parameter int DEPTH  = canny_pkg::WBUF_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [DEPTH-1:0]  match_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            // Push and pop slots never coincide: that would need full and empty at once.
            if (do_push) begin
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: valid_q guards every use of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match_o[i] = valid_q[i] && (addr_q[i] == cmp_addr_i);
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: buffered writes vs pipelined reads, plus drain-then-dump sequencing.
// Latency: read issue same cycle as rd_ack, rd_valid/rd_data 2 cycles later; buffered write issues >= 1 cycle after push.
// Backpressure: rd_req held until rd_ack; wr_full blocks pushes (buffer full, or during DRAIN/DUMP).
// Ports: rd_req/rd_addr -> rd_ack, rd_valid/rd_data; wr_req/wr_addr/wr_data, wr_full;
//        dump_req -> mem_dump; sram_addr/sram_wdata/sram_we/sram_re, sram_rdata; busy.
module sram_arbiter #(
    parameter int ADDR_W     = canny_pkg::ADDR_W,
    parameter int DATA_W     = canny_pkg::DATA_W,
    parameter int WBUF_DEPTH = canny_pkg::WBUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    input  logic              dump_req,
    output logic              mem_dump,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);
    import canny_pkg::*;

    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;
    logic       rd_pend_q;      // read issued last cycle, sram_rdata valid now
    logic       rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [ADDR_W-1:0]     wb_head_addr;
    logic [DATA_W-1:0]     wb_head_data;
    logic [WBUF_DEPTH-1:0] wb_match;
    logic                  wb_full;
    logic                  wb_empty;
    logic [CNT_W-1:0]      wb_count;
    logic                  wb_push;

    logic rd_cand, wr_cand, grant_rd, grant_wr;
    logic hazard, rd_inflight, wb_at_cap;

    wbuf_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wb_push),
        .push_addr_i (wr_addr),
        .push_data_i (wr_data),
        .pop_i       (grant_wr),
        .cmp_addr_i  (rd_addr),
        .head_addr_o (wb_head_addr),
        .head_data_o (wb_head_data),
        .match_o     (wb_match),
        .full_o      (wb_full),
        .empty_o     (wb_empty),
        .count_o     (wb_count)
    );

    assign hazard      = |wb_match;
    assign rd_inflight = rd_pend_q || rd_valid_q;
    assign wb_at_cap   = (wb_count == CNT_W'(WBUF_DEPTH));
    assign wr_full     = wb_full || (state_q != ST_NORMAL);
    assign wb_push     = wr_req && !wr_full;

    // Arbitration. The read side is gated by rst because rd_req is a live input;
    // everything else is already quiet through the async reset of the state.
    always_comb begin
        rd_cand  = rd_req && !rst && (state_q == ST_NORMAL) && !hazard;
        wr_cand  = !wb_empty;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (rd_cand && wr_cand) begin
            if (wb_at_cap || (last_grant_q == GRANT_READ)) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else begin
            grant_rd = rd_cand;
            grant_wr = wr_cand;
        end

        last_grant_d = last_grant_q;
        if (grant_wr) begin
            last_grant_d = GRANT_WRITE;
        end else if (grant_rd) begin
            last_grant_d = GRANT_READ;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_dump = 1'b0;
        case (state_q)
            ST_NORMAL: if (dump_req) state_d = ST_DRAIN;
            // Wait for reads already issued to complete so the dump sees a quiet SRAM.
            ST_DRAIN:  if (wb_empty && !rd_inflight) state_d = ST_DUMP;
            ST_DUMP: begin
                mem_dump = 1'b1;
                state_d  = ST_NORMAL;
            end
            default:   state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            last_grant_q <= GRANT_READ;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= grant_rd;
            rd_valid_q   <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= sram_rdata;
            end
        end
    end

    assign sram_we    = grant_wr;
    assign sram_re    = grant_rd;
    assign rd_ack     = grant_rd;
    assign sram_addr  = grant_wr ? wb_head_addr : rd_addr;
    assign sram_wdata = wb_head_data;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign busy       = !wb_empty || rd_inflight || (state_q != ST_NORMAL);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a queue-based scoreboard and a behavioural SRAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          dump_req;
    logic          mem_dump;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_we;
    logic          sram_re;
    logic [DW-1:0] sram_rdata;
    logic          busy;

    logic [DW-1:0]    sram_mem [0:(1<<AW)-1];
    logic [DW-1:0]    ref_mem  [0:(1<<AW)-1];
    logic [AW+DW-1:0] wr_q[$];
    logic [DW-1:0]    rd_q[$];

    int checks = 0;
    int failures = 0;
    int step = 0;
    int we_seen = 0;
    int rv_seen = 0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
        .dump_req(dump_req), .mem_dump(mem_dump),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM model: read data appears the cycle after sram_re.
    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
        if (sram_re) sram_rdata <= sram_mem[sram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock of directed stimulus plus the hand-computed per-cycle expectations.
    task automatic cyc(input string tag, input logic rq, input logic [AW-1:0] ra,
                       input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic dq, input logic acc,
                       input logic e_we, input logic e_re, input logic e_full, input logic e_dump);
        @(posedge clk); #1;
        rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd; dump_req = dq;
        if (wq && acc) begin
            wr_q.push_back({wa, wd});
            ref_mem[wa] = wd;
        end
        @(negedge clk);
        chk($sformatf("%s.c%0d sram_we", tag, step), sram_we, e_we);
        chk($sformatf("%s.c%0d sram_re", tag, step), sram_re, e_re);
        chk($sformatf("%s.c%0d rd_ack", tag, step), rd_ack, e_re);
        chk($sformatf("%s.c%0d wr_full", tag, step), wr_full, e_full);
        chk($sformatf("%s.c%0d mem_dump", tag, step), mem_dump, e_dump);
        step++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rd_req = 1'b0; wr_req = 1'b0; dump_req = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rd_ack"}, rd_ack, 1'b0);
        chk({tag, " rd_valid"}, rd_valid, 1'b0);
        chk({tag, " mem_dump"}, mem_dump, 1'b0);
        chk({tag, " sram_we"}, sram_we, 1'b0);
        chk({tag, " sram_re"}, sram_re, 1'b0);
        chk({tag, " rd_data"}, rd_data, '0);
        chk({tag, " wr_full"}, wr_full, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes the SRAM or returns read data.
    initial begin
        logic             ack_d1, ack_d2;
        logic [AW+DW-1:0] e;
        ack_d1 = 1'b0;
        ack_d2 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack_d1 = 1'b0;
                ack_d2 = 1'b0;
            end else begin
                if (sram_we || sram_re) chk("we_re_exclusive", sram_we && sram_re, 1'b0);
                if (sram_we) begin
                    we_seen++;
                    chk("write_expected", wr_q.size() != 0, 1'b1);
                    if (wr_q.size() != 0) begin
                        e = wr_q.pop_front();
                        chk("write_addr", sram_addr, e[AW+DW-1:DW]);
                        chk("write_data", sram_wdata, e[DW-1:0]);
                    end
                end
                if (rd_valid || ack_d2) chk("rd_valid_2_after_ack", rd_valid, ack_d2);
                if (rd_valid) begin
                    rv_seen++;
                    chk("read_expected", rd_q.size() != 0, 1'b1);
                    if (rd_q.size() != 0) chk("read_data", rd_data, rd_q.pop_front());
                end
                if (rd_ack) rd_q.push_back(ref_mem[rd_addr]);
                ack_d2 = ack_d1;
                ack_d1 = rd_ack;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, rv0;
        // Reset with every request input active: nothing may leak out.
        rst = 1'b1; rd_req = 1'b1; rd_addr = 18'd5; wr_req = 1'b1;
        wr_addr = '0; wr_data = '0; dump_req = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0; dump_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Write-only: four pushes drain on four consecutive cycles.
        step = 0;
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'(i);
            d = DW'(8'hA0 + i);
            cyc("wronly", 1'b0, '0, i < 4, a, d, 1'b0, 1'b1,
                (i >= 1 && i <= 4), 1'b0, 1'b0, 1'b0);
            chk($sformatf("wronly.c%0d busy", i), busy, (i >= 1 && i <= 4));
        end
        idle(3);

        // Fill under continuous reads: pushes 0..6 accepted, push 7 meets wr_full and is dropped.
        step = 0;
        cyc("full", 1, 18'd2, 1, 18'h100, 8'hB0, 0, 1, 0, 1, 0, 0);
        cyc("full", 1, 18'd2, 1, 18'h101, 8'hB1, 0, 1, 1, 0, 0, 0);
        cyc("full", 1, 18'd2, 1, 18'h102, 8'hB2, 0, 1, 0, 1, 0, 0);
        cyc("full", 1, 18'd2, 1, 18'h103, 8'hB3, 0, 1, 1, 0, 0, 0);
        cyc("full", 1, 18'd2, 1, 18'h104, 8'hB4, 0, 1, 0, 1, 0, 0);
        cyc("full", 1, 18'd2, 1, 18'h105, 8'hB5, 0, 1, 1, 0, 0, 0);
        cyc("full", 1, 18'd2, 1, 18'h106, 8'hB6, 0, 1, 0, 1, 0, 0);
        cyc("full", 1, 18'd2, 1, 18'h107, 8'hB7, 0, 0, 1, 0, 1, 0);
        cyc("full", 1, 18'd2, 0, 18'h0,   8'h00, 0, 0, 0, 1, 0, 0);
        cyc("full", 0, 18'd2, 0, 18'h0,   8'h00, 0, 0, 1, 0, 0, 0);
        cyc("full", 0, 18'd2, 0, 18'h0,   8'h00, 0, 0, 1, 0, 0, 0);
        cyc("full", 0, 18'd2, 0, 18'h0,   8'h00, 0, 0, 1, 0, 0, 0);
        cyc("full", 0, 18'd2, 0, 18'h0,   8'h00, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Contention: reads of 0..3 interleave with writes to 0x200.. one for one.
        step = 0;
        cyc("cont", 1, 18'd0, 1, 18'h200, 8'h40, 0, 1, 0, 1, 0, 0);
        cyc("cont", 1, 18'd1, 1, 18'h201, 8'h41, 0, 1, 1, 0, 0, 0);
        cyc("cont", 1, 18'd1, 1, 18'h202, 8'h42, 0, 1, 0, 1, 0, 0);
        cyc("cont", 1, 18'd2, 1, 18'h203, 8'h43, 0, 1, 1, 0, 0, 0);
        cyc("cont", 1, 18'd2, 1, 18'h204, 8'h44, 0, 1, 0, 1, 0, 0);
        cyc("cont", 1, 18'd3, 1, 18'h205, 8'h45, 0, 1, 1, 0, 0, 0);
        cyc("cont", 1, 18'd3, 0, 18'h0,   8'h00, 0, 0, 0, 1, 0, 0);
        cyc("cont", 0, 18'd0, 0, 18'h0,   8'h00, 0, 0, 1, 0, 0, 0);
        cyc("cont", 0, 18'd0, 0, 18'h0,   8'h00, 0, 0, 1, 0, 0, 0);
        cyc("cont", 0, 18'd0, 0, 18'h0,   8'h00, 0, 0, 1, 0, 0, 0);
        cyc("cont", 0, 18'd0, 0, 18'h0,   8'h00, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Hazard: read of 0x00123 waits until the buffered write to it has issued.
        step = 0;
        cyc("hazard", 0, 18'h0,     1, 18'h600,   8'h11, 0, 1, 0, 0, 0, 0);
        cyc("hazard", 0, 18'h0,     1, 18'h00123, 8'h5A, 0, 1, 1, 0, 0, 0);
        cyc("hazard", 1, 18'h00123, 0, 18'h0,     8'h00, 0, 0, 1, 0, 0, 0);
        cyc("hazard", 1, 18'h00123, 0, 18'h0,     8'h00, 0, 0, 0, 1, 0, 0);
        cyc("hazard", 0, 18'h0,     0, 18'h0,     8'h00, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Dump: three buffered writes drain, then a single mem_dump, then NORMAL again.
        // Pushes and dump_req during DRAIN/DUMP are ignored; reads wait for NORMAL.
        step = 0;
        cyc("dump", 1, 18'd3, 1, 18'h400, 8'hC0, 0, 1, 0, 1, 0, 0);
        cyc("dump", 1, 18'd3, 1, 18'h401, 8'hC1, 0, 1, 1, 0, 0, 0);
        cyc("dump", 1, 18'd3, 1, 18'h402, 8'hC2, 0, 1, 0, 1, 0, 0);
        cyc("dump", 1, 18'd3, 1, 18'h403, 8'hC3, 0, 1, 1, 0, 0, 0);
        cyc("dump", 1, 18'd3, 1, 18'h404, 8'hC4, 0, 1, 0, 1, 0, 0);
        cyc("dump", 0, 18'd3, 0, 18'h0,   8'h00, 1, 0, 1, 0, 0, 0);
        cyc("dump", 1, 18'd3, 1, 18'h4FF, 8'hEE, 0, 0, 1, 0, 1, 0);
        cyc("dump", 1, 18'd3, 0, 18'h0,   8'h00, 1, 0, 1, 0, 1, 0);
        cyc("dump", 1, 18'd3, 0, 18'h0,   8'h00, 0, 0, 0, 0, 1, 0);
        cyc("dump", 1, 18'd3, 0, 18'h0,   8'h00, 1, 0, 0, 0, 1, 1);
        cyc("dump", 1, 18'd3, 0, 18'h0,   8'h00, 0, 0, 0, 1, 0, 0);
        cyc("dump", 0, 18'd3, 0, 18'h0,   8'h00, 0, 0, 0, 0, 0, 0);
        cyc("dump", 0, 18'd3, 0, 18'h0,   8'h00, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Reset one cycle after rd_ack: read cancelled, buffered write discarded.
        step = 0;
        cyc("rstrd", 1, 18'd1, 1, 18'h500, 8'h77, 0, 1, 0, 1, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1; wr_req = 1'b0;
        wr_q.delete();
        rd_q.delete();
        we0 = we_seen;
        rv0 = rv_seen;
        @(negedge clk);
        chk_reset_outputs("rstrd.c1");
        @(negedge clk);
        chk("rstrd.c2 rd_valid", rd_valid, 1'b0);
        chk("rstrd.c2 rd_data", rd_data, '0);
        @(posedge clk); #1;
        rst = 1'b0; rd_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rstrd no rd_valid after reset", rv_seen - rv0, 0);
        chk("rstrd no write after reset", we_seen - we0, 0);

        idle(4);
        @(negedge clk);
        chk("end write queue drained", wr_q.size(), 0);
        chk("end read queue drained", rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters: ADDR_W = 18, pixel address width for a 512x512 frame; DATA_W = 8, pixel width; WBUF_DEPTH = 4, write-buffer entries.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 rd_req  in  1  read request; held high with rd_addr stable until rd_ack.
REQ-005 rd_addr  in  ADDR_W  read address.
REQ-006 rd_ack  out  1  one-cycle pulse; read issued to SRAM this cycle.
REQ-007 rd_valid  out  1  one-cycle pulse; rd_data valid.
REQ-008 rd_data  out  DATA_W  registered read data.
REQ-009 wr_req  in  1  write push; accepted in any cycle where wr_full is low.
REQ-010 wr_addr, wr_data  in  ADDR_W, DATA_W  write address and data.
REQ-011 wr_full  out  1  write buffer cannot accept a push.
REQ-012 dump_req  in  1  pulse requesting a memory dump.
REQ-013 mem_dump  out  1  one-cycle dump strobe to the SRAM model.
REQ-014 sram_addr, sram_wdata  out  ADDR_W, DATA_W  SRAM address and write data.
REQ-015 sram_we, sram_re  out  1  SRAM write and read strobes; never high together.
REQ-016 sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_re.
REQ-017 busy  out  1  high when the buffer is non-empty, a read is in flight, or the FSM is not NORMAL.

Function
REQ-018 Write buffer is a FIFO of WBUF_DEPTH {addr,data} entries; wr_full = (count == WBUF_DEPTH) OR FSM in DRAIN or DUMP.
REQ-019 Push and pop in the same cycle leave count unchanged; a push while wr_full is high is dropped.
REQ-020 Each cycle at most one SRAM operation is issued; all SRAM outputs are combinational from registered state and the current request inputs.
REQ-021 Write issue: sram_we=1, sram_addr/sram_wdata = FIFO head; the head is popped in the same cycle.
REQ-022 Read issue: sram_re=1, sram_addr=rd_addr, rd_ack=1; rd_data is registered from sram_rdata one cycle later; rd_valid is high 2 cycles after rd_ack.
REQ-023 Arbitration with both candidates present: write wins if count == WBUF_DEPTH, else round-robin on a last_grant bit; last_grant updates only on an issued operation.
REQ-024 Hazard: a read is not granted while rd_addr equals any valid buffer entry address; writes drain until there is no match.
REQ-025 Pipelined reads are allowed; a read may be issued every cycle.
REQ-026 FSM states: NORMAL, DRAIN, DUMP.
REQ-027 NORMAL -> DRAIN on dump_req.
REQ-028 DRAIN: no reads granted; writes issue each cycle; -> DUMP when count==0 and no read is in flight.
REQ-029 DUMP: mem_dump=1 for one cycle -> NORMAL.
REQ-030 dump_req received in DRAIN or DUMP is ignored.
REQ-031 Address arithmetic is unsigned ADDR_W bits with no wrap handling; addresses pass through unchanged.

Reset
REQ-032 On rst: FIFO pointers and count = 0, FSM = NORMAL, last_grant = read.
REQ-033 On rst: rd_ack = rd_valid = mem_dump = sram_we = sram_re = 0, rd_data = 0, wr_full = 0, busy = 0.
REQ-034 On rst: in-flight reads are cancelled with no rd_valid emitted; buffered writes are discarded.

Structure
REQ-035 Shared package canny_pkg holds ADDR_W, DATA_W, IMG_W = 512, IMG_H = 512, and the arb_state_t enum.
REQ-036 The write buffer is the sub-module wbuf_fifo, exposing push/pop/full/empty/count and per-entry address match outputs.

Verification
REQ-037 Write-only: 4 pushes (addr 0..3, data A0..A3) with no reads -> sram_we on 4 consecutive cycles in order; wr_full never high.
REQ-038 Full buffer: 5 pushes with reads blocked -> wr_full high after the 4th push; the 5th push is dropped; once reads are enabled, writes win until count < 4.
REQ-039 Contention: continuous rd_req and wr_req with count < 4 -> read and write alternate; rd_valid high 2 cycles after each rd_ack with correct data.
REQ-040 Hazard: buffer holds addr 0x00123; rd_req for 0x00123 -> rd_ack only after that write issues; rd_data equals the written value.
REQ-041 Dump: dump_req with 3 entries buffered -> 3 sram_we cycles, then mem_dump pulse, then NORMAL; wr_full high throughout.
REQ-042 Reset mid-read: rst asserted 1 cycle after rd_ack -> no rd_valid; all outputs at reset values immediately.
